uart_tx_unit: RTL and testbench

//  Serial transmitter that consumes CPU_FSM's transmit_reg_en / transmit_enable strobes and returns
//  its "transmitting" busy flag. Latches a 16-bit register value, then sends it on a UART line as
//  NUM_BYTES 8N1 frames, least-significant byte first, each byte LSB first. Sits between the

---
 rtl/uart_tx_unit.sv | 143 ++++++++++++++
 tb/tb_uart_tx_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: latches a 16-bit register value and sends NUM_BYTES 8N1 frames,
// least-significant byte first, with registered tx/transmitting/tx_done outputs.
module uart_tx_unit #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int NUM_BYTES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        transmit_reg_en,
    input  logic        transmit_enable,
    output logic        tx,
    output logic        transmitting,
    output logic        tx_done
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [1:0]       byte_idx, byte_idx_next;
    logic [15:0]      shift_reg, shift_next;
    logic [15:0]      hold_reg, hold_next;
    logic             tx_next, transmitting_next, tx_done_next;
    logic             bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            shift_reg    <= '0;
            hold_reg     <= '0;
            tx           <= 1'b1;
            transmitting <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            state        <= state_next;
            baud_cnt     <= baud_cnt_next;
            bit_idx      <= bit_idx_next;
            byte_idx     <= byte_idx_next;
            shift_reg    <= shift_next;
            hold_reg     <= hold_next;
            tx           <= tx_next;
            transmitting <= transmitting_next;
            tx_done      <= tx_done_next;
        end
    end

    // Outputs are computed from the next state so the registered line never glitches.
    // The data bit leaving DATA still shifts, so after byte 0 the low byte holds byte 1.
    always_comb begin
        state_next        = state;
        baud_cnt_next     = baud_cnt;
        bit_idx_next      = bit_idx;
        byte_idx_next     = byte_idx;
        shift_next        = shift_reg;
        hold_next         = hold_reg;
        tx_next           = tx;
        transmitting_next = transmitting;
        tx_done_next      = 1'b0;

        if (transmit_reg_en && !transmitting) begin
            hold_next = data_in;
        end

        case (state)
            IDLE: begin
                tx_next           = 1'b1;
                transmitting_next = 1'b0;
                if (transmit_enable) begin
                    state_next        = START;
                    baud_cnt_next     = '0;
                    bit_idx_next      = '0;
                    byte_idx_next     = '0;
                    shift_next        = transmit_reg_en ? data_in : hold_reg;
                    tx_next           = 1'b0;
                    transmitting_next = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next    = DATA;
                    baud_cnt_next = '0;
                    tx_next       = shift_reg[0];
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    shift_next    = shift_reg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_next   = DONE;
                        tx_next      = 1'b1;
                        tx_done_next = 1'b1;
                    end else begin
                        state_next    = START;
                        byte_idx_next = byte_idx + 2'd1;
                        bit_idx_next  = '0;
                        tx_next       = 1'b0;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_next        = IDLE;
                tx_next           = 1'b1;
                transmitting_next = 1'b0;
            end
            default: begin
                state_next        = IDLE;
                tx_next           = 1'b1;
                transmitting_next = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit: a 2-byte and a 1-byte build decoded at bit centres
// against a word-level model of the holding register and the 8N1 line format.
module tb_uart_tx_unit;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int CPB    = 10;

    typedef struct {
        logic [15:0] word;
        int          nbytes;
        int          abort_len;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        reg_en_a, te_a, reg_en_b, te_b;
    logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] model_hold[2];
    bit          model_busy[2];
    int          nbytes_of[2] = '{2, 1};
    int          checks = 0;
    int          fails  = 0;

    uart_tx_unit #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_BYTES(2)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .transmit_reg_en(reg_en_a),
        .transmit_enable(te_a), .tx(tx_a), .transmitting(busy_a), .tx_done(done_a)
    );

    uart_tx_unit #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NUM_BYTES(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in), .transmit_reg_en(reg_en_b),
        .transmit_enable(te_b), .tx(tx_b), .transmitting(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Line level of bit j (0 = start, 1..8 = data LSB first, 9 = stop) of byte b.
    function automatic logic line_bit(input logic [15:0] word, input int b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return word[8*b + j - 1];
    endfunction

    function automatic void sample(input int which, output logic t, output logic b, output logic d);
        if (which == 0) begin
            t = tx_a; b = busy_a; d = done_a;
        end else begin
            t = tx_b; b = busy_b; d = done_b;
        end
    endfunction

    task automatic drive(input int which, input logic r, input logic t);
        if (which == 0) begin
            reg_en_a = r; te_a = t;
        end else begin
            reg_en_b = r; te_b = t;
        end
    endtask

    task automatic load_holding(input int which, input logic [15:0] word);
        data_in = word;
        drive(which, 1'b1, 1'b0);
        if (!model_busy[which]) model_hold[which] = word;
        @(negedge clk);
        drive(which, 1'b0, 1'b0);
    endtask

    task automatic apply_stimulus(input int which, input bit bypass, input logic [15:0] word,
                                  input int gap, input int abort_len);
        exp_t e;
        data_in = word;
        drive(which, bypass, 1'b1);
        if (!model_busy[which]) begin
            if (bypass) model_hold[which] = word;
            e.word      = model_hold[which];
            e.nbytes    = nbytes_of[which];
            e.abort_len = abort_len;
            e.gap       = gap;
            if (which == 0) q_a.push_back(e);
            else q_b.push_back(e);
            model_busy[which] = 1'b1;
        end
        @(posedge clk);
        #1;
        drive(which, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input int which);
        logic t, b, d;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            sample(which, t, b, d);
            n++;
        end while (b !== 1'b0 && n < 400);
        check_output("wait_idle", b, 1'b0);
        model_busy[which] = 1'b0;
    endtask

    task automatic monitor(input int which);
        logic  t, b, d;
        exp_t  e;
        bit    have;
        string tag;
        int    idle_run, idle_bad, k, low_start, done_cnt, done_pos, pos, full;
        tag = (which == 0) ? "a" : "b";
        idle_run = 0;
        idle_bad = 0;
        forever begin
            @(negedge clk);
            sample(which, t, b, d);
            if (b !== 1'b1) begin
                idle_run++;
                if (t !== 1'b1 || d !== 1'b0) idle_bad++;
            end else begin
                have = 1'b0;
                if (which == 0 && q_a.size() > 0) begin
                    e = q_a.pop_front(); have = 1'b1;
                end else if (which == 1 && q_b.size() > 0) begin
                    e = q_b.pop_front(); have = 1'b1;
                end
                check_output({tag, "_frame_expected"}, have, 1);
                check_output({tag, "_idle_line"}, idle_bad, 0);
                if (have && e.gap >= 0) check_output({tag, "_start_gap"}, idle_run, e.gap);
                full = have ? e.nbytes * 10 * CPB : 0;
                k = 0; low_start = 0; done_cnt = 0; done_pos = -1;
                while (b === 1'b1 && k < 400) begin
                    if (k < CPB && t === 1'b0) low_start++;
                    if (d === 1'b1) begin
                        done_cnt++;
                        done_pos = k;
                    end
                    if (have && e.abort_len == 0 && k < full && (k % CPB) == CPB / 2) begin
                        pos = k / CPB;
                        check_output($sformatf("%s_byte%0d_bit%0d", tag, pos / 10, pos % 10),
                                     t, line_bit(e.word, pos / 10, pos % 10));
                    end
                    k++;
                    @(negedge clk);
                    sample(which, t, b, d);
                end
                if (have && e.abort_len > 0) begin
                    check_output({tag, "_abort_len"}, k, e.abort_len);
                    check_output({tag, "_abort_no_done"}, done_cnt, 0);
                end else if (have) begin
                    check_output({tag, "_busy_len"}, k, full + 1);
                    check_output({tag, "_done_count"}, done_cnt, 1);
                    check_output({tag, "_done_pos"}, done_pos, full);
                    check_output({tag, "_start_low"}, low_start, CPB);
                end
                idle_run = 0;
                idle_bad = 0;
                if (b !== 1'b1) begin
                    idle_run = 1;
                    if (t !== 1'b1 || d !== 1'b0) idle_bad++;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        int          which, last_which, mode, d, gap;
        logic [15:0] w;
        rst = 1'b0;
        data_in = '0;
        reg_en_a = 1'b0; te_a = 1'b0; reg_en_b = 1'b0; te_b = 1'b0;
        model_hold = '{16'h0, 16'h0};
        model_busy = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check_output("reset_tx_a", tx_a, 1'b1);
        check_output("reset_busy_a", busy_a, 1'b0);
        check_output("reset_done_a", done_a, 1'b0);
        check_output("reset_tx_b", tx_b, 1'b1);
        check_output("reset_busy_b", busy_b, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Known word, then a start with busy-time load/start strobes that must be ignored.
        load_holding(0, 16'h4A31);
        apply_stimulus(0, 1'b0, 16'h0, -1, 0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        apply_stimulus(0, 1'b0, 16'hC3C3, -1, 0);
        repeat (60) @(negedge clk);
        apply_stimulus(0, 1'b1, 16'h1234, -1, 0);
        @(negedge clk);
        load_holding(0, 16'h1234);
        wait_idle(0);
        repeat (30) @(negedge clk);
        apply_stimulus(0, 1'b0, 16'h7777, -1, 0);
        wait_idle(0);

        // Same-cycle bypass, then two back-to-back starts right after busy falls.
        apply_stimulus(0, 1'b1, 16'h00FF, 1, 0);
        wait_idle(0);
        apply_stimulus(0, 1'b0, 16'hAAAA, 1, 0);
        wait_idle(0);

        load_holding(1, 16'h00A5);
        apply_stimulus(1, 1'b0, 16'h0, -1, 0);
        wait_idle(1);

        // Reset asserted mid-frame, then a start must send the cleared holding register.
        @(negedge clk);
        apply_stimulus(0, 1'b1, 16'hBEEF, -1, 57);
        repeat (57) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_output("abort_tx", tx_a, 1'b1);
        check_output("abort_busy", busy_a, 1'b0);
        check_output("abort_done", done_a, 1'b0);
        model_hold = '{16'h0, 16'h0};
        model_busy = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 1'b0, 16'h5A5A, -1, 0);
        wait_idle(0);

        last_which = 0;
        for (int i = 0; i < 10; i++) begin
            which = (i % 4 == 3) ? 1 : 0;
            mode  = $urandom_range(0, 2);
            d     = $urandom_range(0, 4);
            w     = 16'($urandom);
            gap   = (which == last_which) ? 1 + d + ((mode == 1) ? 1 : 0) : -1;
            repeat (d) @(negedge clk);
            if (mode == 1) load_holding(which, w);
            apply_stimulus(which, mode == 2, w, gap, 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 80)) @(negedge clk);
                apply_stimulus(which, 1'b1, 16'($urandom), -1, 0);
            end
            wait_idle(which);
            last_which = which;
        end

        repeat (20) @(negedge clk);
        check_output("queue_a_drained", q_a.size(), 0);
        check_output("queue_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
